ec_core_serial_shell: RTL and testbench
=======================================

Name: ec_core_serial_shell

Overview:
Parametrised serial test shell for any start/done EC arithmetic core, such as point multipliers and field units.
- Deserialises a frame of IN_WIDTH bits from one pin and drives it onto the core's input bus.
- Issues a one-cycle core_start, then waits for core_done.
- Captures the core's OUT_WIDTH-bit result and serialises it back out on one pin with a valid strobe.
- Sits at the FPGA top, between the pins and the core, so that a wide core can be synthesised and tested with two data pins.

Parameters:
IN_WIDTH, 236, number of bits deserialised and presented on core_din (minimum 1)
OUT_WIDTH, 467, number of bits captured from core_dout and serialised (minimum 1)
TMO_W, 20, width of the WAIT timeout counter (used only with the optional feature)

Ports:
clk  input  1  system clock
rst_n  input  1  asynchronous active-low reset
clr  input  1  synchronous abort; returns FSM to IDLE and clears state
ser_in  input  1  serial input data, MSB of frame first
ser_in_vld  input  1  qualifies ser_in; bit sampled on rising clk when high in LOAD
ser_out  output  1  serial result data, MSB first
ser_out_vld  output  1  high while ser_out carries a valid result bit
busy  output  1  high in any state except IDLE
core_din  output  IN_WIDTH  registered input frame to core, stable from START to end of UNLOAD
core_start  output  1  one-cycle start pulse to core
core_done  input  1  core completion flag, level or pulse
core_dout  input  OUT_WIDTH  core result, sampled when core_done is seen in WAIT
err_tmo  output  1  sticky timeout flag; constant 0 without the optional feature

Behaviour:
- Reset (rst_n low, asynchronous): state IDLE; all outputs 0, including core_din and both shift registers; counters 0.
- clr high: same effect synchronously on the next edge; it overrides every other event in that cycle.
- States: IDLE, LOAD, START, WAIT, UNLOAD.
- IDLE:
  - First ser_in_vld=1 sample moves to LOAD and is counted as frame bit IN_WIDTH-1.
  - ser_in is ignored while ser_in_vld=0.
- LOAD:
  - Each valid bit shifts into the input register from the LSB side; bit counter increments.
  - ser_in_vld low stalls the counter with no timeout.
  - The edge that samples bit index 0 (the IN_WIDTH-th bit) goes to START.
  - If IN_WIDTH=1, IDLE goes directly to START.
- START: core_start=1 for exactly one cycle; core_din holds the frame. Next state is WAIT.
- WAIT:
  - core_done is sampled only in WAIT, so any done asserted during START is ignored.
  - On core_done=1: capture core_dout into the output shift register on the same edge, then go to UNLOAD.
- UNLOAD:
  - ser_out = output shift register MSB; ser_out_vld=1; shift left once per cycle.
  - Exactly OUT_WIDTH cycles, then IDLE with ser_out and ser_out_vld at 0.
- Latency: last input bit sampled at edge N gives core_start high in cycle N+1. core_done seen at edge M gives the first result bit in cycle M+1.
- Any ser_in_vld during START, WAIT or UNLOAD is dropped. A new frame is accepted only from IDLE.
- Counter widths: $clog2(IN_WIDTH+1) and $clog2(OUT_WIDTH+1). The counters never wrap.

Optional Feature:
- Macro: EC_SHELL_TIMEOUT_EN.
- Defined:
  - A TMO_W-bit counter runs in WAIT.
  - When it reaches all-ones without core_done, err_tmo is set (sticky until reset or clr).
  - The FSM then enters UNLOAD, serialising OUT_WIDTH zero bits with ser_out_vld=1.
- Undefined: no counter; WAIT lasts until core_done; err_tmo is tied 0.

Decomposition:
- Package ec_shell_pkg: state enum (IDLE, LOAD, START, WAIT, UNLOAD) and the counter-width helper function.
- One natural sub-module, ec_shell_piso: parallel-load, serial-out register with a bit counter, used for UNLOAD.
- The SIPO path stays inline.

Test Plan (bench at IN_WIDTH=8, OUT_WIDTH=12, TMO_W=6):
- Serial load of 0xA5 with ser_in_vld continuous -> core_din=0xA5 and a single core_start pulse one cycle after the 8th bit; busy=1.
- Load with ser_in_vld low for 3 cycles mid-frame -> core_din still 0xA5; start delayed by exactly 3 cycles.
- Model core asserts done 10 cycles after start with dout=0xC3F -> ser_out_vld high for 12 cycles with bits 1100_0011_1111, then IDLE and busy=0.
- core_done held high during START -> ignored; capture happens on the first WAIT cycle. ser_in pulses during UNLOAD -> no effect on the next frame.
- rst_n low during WAIT, and separately clr high during UNLOAD -> all outputs 0 immediately (reset) or next edge (clr); a fresh 0x3C frame then loads correctly.
- With EC_SHELL_TIMEOUT_EN and core_done never asserted -> after 63 WAIT cycles err_tmo=1 and 12 zero bits are output; without the macro -> still in WAIT after 200 cycles, err_tmo=0.

Source files
------------

// File: rtl/ec_shell_pkg.sv
// Shared types and helpers for the EC core serial test shell.
package ec_shell_pkg;

   typedef enum logic [2:0] {
      StIdle,
      StLoad,
      StStart,
      StWait,
      StUnload
   } shell_state_e;

   // Width of a counter that must hold values 0..n inclusive.
   function automatic int unsigned cnt_w(input int unsigned n);
      return $clog2(n + 1);
   endfunction

endpackage

// File: rtl/ec_shell_piso.sv
// Parallel-load, serial-out register (MSB first) with a remaining-bit counter.
module ec_shell_piso
   import ec_shell_pkg::*;
#(
   parameter int unsigned WIDTH = 467
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             clr,
   input  logic             load,
   input  logic [WIDTH-1:0] din,
   input  logic             shift,
   output logic             ser_out,
   output logic             last
);

   localparam int unsigned CntW = cnt_w(WIDTH);

   logic [WIDTH-1:0] data_q, data_d;
   logic [CntW-1:0]  cnt_q, cnt_d;

   always_comb begin
      data_d = data_q;
      cnt_d  = cnt_q;
      if (clr) begin
         data_d = '0;
         cnt_d  = '0;
      end else if (load) begin
         data_d = din;
         cnt_d  = CntW'(WIDTH);
      end else if (shift && cnt_q != '0) begin
         // Zero fill leaves the register empty once every bit has gone out.
         data_d = data_q << 1;
         cnt_d  = cnt_q - 1'b1;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         data_q <= '0;
         cnt_q  <= '0;
      end else begin
         data_q <= data_d;
         cnt_q  <= cnt_d;
      end
   end

   assign ser_out = data_q[WIDTH-1];
   assign last    = (cnt_q == CntW'(1));

endmodule

// File: rtl/ec_core_serial_shell.sv
// Serial test shell around a start/done EC core: load frame, start, wait, unload result.
// Optional WAIT timeout with sticky err_tmo is enabled by defining EC_SHELL_TIMEOUT_EN.
module ec_core_serial_shell
   import ec_shell_pkg::*;
#(
   parameter int unsigned IN_WIDTH  = 236,
   parameter int unsigned OUT_WIDTH = 467,
   parameter int unsigned TMO_W     = 20
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic                 clr,
   input  logic                 ser_in,
   input  logic                 ser_in_vld,
   output logic                 ser_out,
   output logic                 ser_out_vld,
   output logic                 busy,
   output logic [IN_WIDTH-1:0]  core_din,
   output logic                 core_start,
   input  logic                 core_done,
   input  logic [OUT_WIDTH-1:0] core_dout,
   output logic                 err_tmo
);

   localparam int unsigned InCntW = cnt_w(IN_WIDTH);
   localparam logic [InCntW-1:0] InLast = InCntW'(IN_WIDTH - 1);

   shell_state_e state_q, state_d;
   logic [IN_WIDTH-1:0]  sipo_q, sipo_d;
   logic [InCntW-1:0]    in_cnt_q, in_cnt_d;
   logic                 piso_load;
   logic [OUT_WIDTH-1:0] piso_din;
   logic                 piso_last;
   logic                 piso_ser;

`ifdef EC_SHELL_TIMEOUT_EN
   localparam logic [TMO_W-1:0] TmoLast = ~TMO_W'(1);
   logic [TMO_W-1:0] tmo_q, tmo_d;
   logic             err_q, err_d;
`else
   logic [TMO_W-1:0] unused_tmo;
   assign unused_tmo = '0;
`endif

   always_comb begin
      state_d   = state_q;
      sipo_d    = sipo_q;
      in_cnt_d  = in_cnt_q;
      piso_load = 1'b0;
      piso_din  = core_dout;
`ifdef EC_SHELL_TIMEOUT_EN
      tmo_d     = '0;
      err_d     = err_q;
`endif
      unique case (state_q)
         StIdle: begin
            if (ser_in_vld) begin
               sipo_d = (sipo_q << 1) | IN_WIDTH'(ser_in);
               if (IN_WIDTH == 1) begin
                  state_d = StStart;
               end else begin
                  in_cnt_d = InCntW'(1);
                  state_d  = StLoad;
               end
            end
         end
         StLoad: begin
            if (ser_in_vld) begin
               sipo_d = (sipo_q << 1) | IN_WIDTH'(ser_in);
               if (in_cnt_q == InLast) begin
                  in_cnt_d = '0;
                  state_d  = StStart;
               end else begin
                  in_cnt_d = in_cnt_q + 1'b1;
               end
            end
         end
         StStart: state_d = StWait;
         StWait: begin
            if (core_done) begin
               piso_load = 1'b1;
               state_d   = StUnload;
            end
`ifdef EC_SHELL_TIMEOUT_EN
            else if (tmo_q == TmoLast) begin
               // Counter would reach all-ones: give up and stream out zeros.
               err_d     = 1'b1;
               piso_load = 1'b1;
               piso_din  = '0;
               state_d   = StUnload;
            end else begin
               tmo_d = tmo_q + 1'b1;
            end
`endif
         end
         StUnload: begin
            if (piso_last) state_d = StIdle;
         end
         default: state_d = StIdle;
      endcase
      if (clr) begin
         state_d   = StIdle;
         sipo_d    = '0;
         in_cnt_d  = '0;
         piso_load = 1'b0;
`ifdef EC_SHELL_TIMEOUT_EN
         tmo_d     = '0;
         err_d     = 1'b0;
`endif
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q  <= StIdle;
         sipo_q   <= '0;
         in_cnt_q <= '0;
      end else begin
         state_q  <= state_d;
         sipo_q   <= sipo_d;
         in_cnt_q <= in_cnt_d;
      end
   end

`ifdef EC_SHELL_TIMEOUT_EN
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         tmo_q <= '0;
         err_q <= 1'b0;
      end else begin
         tmo_q <= tmo_d;
         err_q <= err_d;
      end
   end
   assign err_tmo = err_q;
`else
   assign err_tmo = 1'b0;
`endif

   ec_shell_piso #(
      .WIDTH (OUT_WIDTH)
   ) u_piso (
      .clk     (clk),
      .rst_n   (rst_n),
      .clr     (clr),
      .load    (piso_load),
      .din     (piso_din),
      .shift   (state_q == StUnload),
      .ser_out (piso_ser),
      .last    (piso_last)
   );

   assign ser_out     = piso_ser;
   assign ser_out_vld = (state_q == StUnload);
   assign busy        = (state_q != StIdle);
   assign core_start  = (state_q == StStart);
   assign core_din    = sipo_q;

endmodule

// File: tb/tb_ec_core_serial_shell.sv
// Scoreboard bench for ec_core_serial_shell at IN_WIDTH=8, OUT_WIDTH=12, TMO_W=6.
module tb_ec_core_serial_shell;

   localparam int unsigned InW  = 8;
   localparam int unsigned OutW = 12;

   logic            clk = 1'b0;
   logic            rst_n = 1'b0;
   logic            clr = 1'b0;
   logic            ser_in = 1'b0;
   logic            ser_in_vld = 1'b0;
   logic            ser_out;
   logic            ser_out_vld;
   logic            busy;
   logic [InW-1:0]  core_din;
   logic            core_start;
   logic            core_done = 1'b0;
   logic [OutW-1:0] core_dout = '0;
   logic            err_tmo;

   int n_checks = 0;
   int n_errors = 0;
   int cyc = 0;

   logic [InW-1:0] din_sb[$];
   logic           res_sb[$];

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   ec_core_serial_shell #(
      .IN_WIDTH  (InW),
      .OUT_WIDTH (OutW),
      .TMO_W     (6)
   ) dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .clr         (clr),
      .ser_in      (ser_in),
      .ser_in_vld  (ser_in_vld),
      .ser_out     (ser_out),
      .ser_out_vld (ser_out_vld),
      .busy        (busy),
      .core_din    (core_din),
      .core_start  (core_start),
      .core_done   (core_done),
      .core_dout   (core_dout),
      .err_tmo     (err_tmo)
   );

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   task automatic check_idle(input string tag);
      check(tag, {busy, ser_out, ser_out_vld, core_start, err_tmo, core_din}, 64'h0);
   endtask

   // Shift a frame in MSB first, optionally with a vld-low gap; returns at the START negedge.
   task automatic send_frame(input logic [InW-1:0] f, input int stall_at, input int stall_len);
      int c0;
      bit seen;
      din_sb.push_back(f);
      @(posedge clk); #1;
      c0 = cyc;
      for (int j = 0; j < InW; j++) begin
         if (j == stall_at) begin
            for (int s = 0; s < stall_len; s++) begin
               ser_in_vld = 1'b0;
               ser_in = 1'($urandom);
               @(posedge clk); #1;
            end
         end
         ser_in_vld = 1'b1;
         ser_in = f[InW-1-j];
         @(posedge clk); #1;
      end
      ser_in_vld = 1'b0;
      seen = 1'b0;
      for (int k = 0; k < 20 && !seen; k++) begin
         @(negedge clk);
         seen = core_start;
      end
      check("start_seen", 64'(seen), 64'd1);
      check("start_latency", 64'(cyc - c0), 64'(InW + stall_len));
      check("core_din", 64'(core_din), 64'(din_sb.pop_front()));
      check("busy_start", 64'(busy), 64'd1);
   endtask

   // Model core; called at the START negedge. hold drives done (with junk data) during START.
   task automatic core_respond(input int delay, input logic [OutW-1:0] dout, input bit hold);
      if (hold) begin
         core_done = 1'b1;
         core_dout = ~dout;
         @(posedge clk); #1;
         check("start_pulse", 64'(core_start), 64'd0);
         core_dout = dout;
      end else begin
         core_done = 1'b0;
         @(posedge clk); #1;
         check("start_pulse", 64'(core_start), 64'd0);
         repeat (delay - 1) @(posedge clk);
         #1;
         core_done = 1'b1;
         core_dout = dout;
      end
      for (int i = OutW - 1; i >= 0; i--) res_sb.push_back(dout[i]);
      @(posedge clk); #1;
      core_done = 1'b0;
      core_dout = 12'h5A5;
   endtask

   task automatic collect(input int nbits, input bit poke, input bit final_chk);
      for (int i = 0; i < nbits; i++) begin
         @(negedge clk);
         check("ser_out_vld", 64'(ser_out_vld), 64'd1);
         if (res_sb.size() == 0) check("sb_empty", 64'd1, 64'd0);
         else check($sformatf("ser_out_bit%0d", i), 64'(ser_out), 64'(res_sb.pop_front()));
         if (poke) begin
            ser_in_vld = 1'($urandom);
            ser_in = 1'($urandom);
         end
      end
      ser_in_vld = 1'b0;
      if (final_chk) begin
         @(negedge clk);
         check("unload_end", {61'h0, busy, ser_out, ser_out_vld}, 64'h0);
      end
   endtask

   initial begin
      #2;
      check_idle("reset_state");
      #20;
      @(negedge clk);
      rst_n = 1'b1;

      // Continuous load, done 10 cycles after start.
      send_frame(8'hA5, -1, 0);
      core_respond(10, 12'hC3F, 1'b0);
      collect(OutW, 1'b0, 1'b1);

      // Mid-frame stall of 3 cycles; serial input noise during unload.
      send_frame(8'hA5, 4, 3);
      core_respond(10, 12'h5A6, 1'b0);
      collect(OutW, 1'b1, 1'b1);

      // Done held through START must not be captured until WAIT.
      send_frame(8'h96, -1, 0);
      core_respond(0, 12'h81E, 1'b1);
      collect(OutW, 1'b0, 1'b1);

      // Asynchronous reset in WAIT, then a fresh frame.
      send_frame(8'hFF, -1, 0);
      repeat (3) @(posedge clk);
      #1 rst_n = 1'b0;
      #1 check_idle("async_reset");
      @(posedge clk); #1 rst_n = 1'b1;
      send_frame(8'h3C, 2, 1);
      core_respond(4, 12'h123, 1'b0);
      collect(OutW, 1'b0, 1'b1);

      // Synchronous clear mid-unload, then a fresh frame.
      send_frame(8'h3C, -1, 0);
      core_respond(2, 12'hABC, 1'b0);
      collect(5, 1'b0, 1'b0);
      @(negedge clk) clr = 1'b1;
      @(posedge clk); #1;
      check_idle("clr_unload");
      clr = 1'b0;
      res_sb.delete();
      send_frame(8'h3C, -1, 0);
      core_respond(3, 12'h9F0, 1'b0);
      collect(OutW, 1'b0, 1'b1);

      // Core never completes.
      send_frame(8'h71, -1, 0);
`ifdef EC_SHELL_TIMEOUT_EN
      begin
         int waits;
         waits = 0;
         @(negedge clk);
         while (!ser_out_vld && waits < 200) begin
            waits++;
            @(negedge clk);
         end
         check("tmo_wait_cycles", 64'(waits), 64'd63);
         check("err_tmo_set", 64'(err_tmo), 64'd1);
         for (int i = 0; i < OutW; i++) res_sb.push_back(1'b0);
         // First zero bit is already on the pins at this negedge.
         check("tmo_bit0", {62'h0, ser_out_vld, ser_out}, 64'h2);
         void'(res_sb.pop_front());
         collect(OutW - 1, 1'b0, 1'b1);
         check("err_tmo_sticky", 64'(err_tmo), 64'd1);
      end
`else
      repeat (200) @(negedge clk);
      check("still_wait", {61'h0, busy, ser_out_vld, err_tmo}, 64'h4);
`endif
      @(negedge clk) clr = 1'b1;
      @(posedge clk); #1;
      check_idle("clr_final");
      clr = 1'b0;

      $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
      $finish;
   end

endmodule
